// File: rtl/rr_arb_defs.sv
// Shared definitions for the round-robin mux arbiter: FSM encodings, requester
// count, select width and a one-hot decode helper.
package rr_arb_defs;

   localparam int NREQ = 4;
   localparam int SELW = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic logic [NREQ-1:0] sel_onehot(input logic [SELW-1:0] sel);
      return {{(NREQ-1){1'b0}}, 1'b1} << sel;
   endfunction

endpackage

// File: rtl/mux4_sel.sv
// DW-wide 4:1 select mux; purely combinational, gating is left to the caller.
module mux4_sel #(
   parameter int DW = 1
) (
   input  logic [DW-1:0] i0,
   input  logic [DW-1:0] i1,
   input  logic [DW-1:0] i2,
   input  logic [DW-1:0] i3,
   input  logic [1:0]    s,
   output logic [DW-1:0] y
);

   // Route the selected input to y.
   always_comb begin
      y = i3;
      case (s)
         2'd0:    y = i0;
         2'd1:    y = i1;
         2'd2:    y = i2;
         default: y = i3;
      endcase
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux select. Define ARB_HOLD_LIMIT_EN to
// force rotation after MAX_HOLD consecutive grant cycles when others are waiting.
module rr_mux_arbiter
   import rr_arb_defs::*;
#(
   parameter int DW       = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    req,
   input  logic [DW-1:0] i0,
   input  logic [DW-1:0] i1,
   input  logic [DW-1:0] i2,
   input  logic [DW-1:0] i3,
   output logic [3:0]    gnt,
   output logic [1:0]    s,
   output logic          valid,
   output logic [DW-1:0] out
);

   if (MAX_HOLD < 1) begin : g_bad_hold
      $error("MAX_HOLD must be at least 1");
   end

   state_t            state_r, state_n;
   logic [NREQ-1:0]   gnt_r, gnt_n;
   logic [SELW-1:0]   s_r, s_n;
   logic              valid_r, valid_n;
   logic [SELW-1:0]   ptr_r, ptr_n;
   logic [SELW-1:0]   start_s;
   logic [SELW:0]     win_s;
   logic              release_s;
   logic              timeout_s;
   logic [DW-1:0]     mux_y_s;

`ifdef ARB_HOLD_LIMIT_EN
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   logic [HW-1:0] hold_cnt_r, hold_cnt_n;
`endif

   // Circular first-set search from start; returns {found, index}.
   function automatic logic [SELW:0] rr_search(input logic [NREQ-1:0] r,
                                               input logic [SELW-1:0] start);
      logic [SELW:0]   res;
      logic [SELW-1:0] idx;
      res = {(SELW+1){1'b0}};
      // Scan farthest-first so the nearest set bit to start is the last write.
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = start + SELW'(k);
         if (r[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   // Search origin: ptr while idle, one past the owner when releasing from GRANT.
   always_comb begin
      start_s = ptr_r;
      if (state_r == ST_GRANT) begin
         start_s = s_r + 2'd1;
      end else begin
         start_s = ptr_r;
      end
   end

   assign win_s = rr_search(req, start_s);

   // Forced-rotation condition for a long-held grant.
   always_comb begin
      timeout_s = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      if ((hold_cnt_r == HOLD_LAST) && ((req & ~gnt_r) != 4'b0000)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
`endif
   end

   assign release_s = (state_r == ST_GRANT) && (!req[s_r] || timeout_s);

   // Next-state and next-output logic of the arbitration FSM.
   always_comb begin
      state_n = state_r;
      gnt_n   = gnt_r;
      s_n     = s_r;
      valid_n = valid_r;
      ptr_n   = ptr_r;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_n = hold_cnt_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (win_s[SELW]) begin
               state_n = ST_GRANT;
               gnt_n   = sel_onehot(win_s[SELW-1:0]);
               s_n     = win_s[SELW-1:0];
               valid_n = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
               hold_cnt_n = {HW{1'b0}};
`endif
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (release_s) begin
               // Release and re-arbitrate in the same edge: no idle bubble.
               ptr_n = start_s;
               if (win_s[SELW]) begin
                  state_n = ST_GRANT;
                  gnt_n   = sel_onehot(win_s[SELW-1:0]);
                  s_n     = win_s[SELW-1:0];
                  valid_n = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                  hold_cnt_n = {HW{1'b0}};
`endif
               end else begin
                  state_n = ST_IDLE;
                  gnt_n   = 4'b0000;
                  valid_n = 1'b0;
               end
            end else begin
`ifdef ARB_HOLD_LIMIT_EN
               hold_cnt_n = (hold_cnt_r == HOLD_LAST) ? {HW{1'b0}} : hold_cnt_r + HW'(1);
`endif
               state_n = ST_GRANT;
            end
         end
         default: begin
            state_n = ST_IDLE;
            gnt_n   = 4'b0000;
            valid_n = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         gnt_r   <= 4'b0000;
         s_r     <= 2'd0;
         valid_r <= 1'b0;
         ptr_r   <= 2'd0;
`ifdef ARB_HOLD_LIMIT_EN
         hold_cnt_r <= {HW{1'b0}};
`endif
      end else begin
         state_r <= state_n;
         gnt_r   <= gnt_n;
         s_r     <= s_n;
         valid_r <= valid_n;
         ptr_r   <= ptr_n;
`ifdef ARB_HOLD_LIMIT_EN
         hold_cnt_r <= hold_cnt_n;
`endif
      end
   end

   mux4_sel #(.DW(DW)) u_mux (
      .i0 (i0),
      .i1 (i1),
      .i2 (i2),
      .i3 (i3),
      .s  (s_r),
      .y  (mux_y_s)
   );

   assign gnt   = gnt_r;
   assign s     = s_r;
   assign valid = valid_r;
   assign out   = valid_r ? mux_y_s : {DW{1'b0}};

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed scenarios plus random traffic
// checked against an owner/pointer reference model.
module tb_rr_mux_arbiter;

   localparam int DW       = 4;
   localparam int MAX_HOLD = 4;
`ifdef ARB_HOLD_LIMIT_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [DW-1:0] din [4];
   logic [3:0]    gnt;
   logic [1:0]    s;
   logic          valid;
   logic [DW-1:0] out;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .i0    (din[0]),
      .i1    (din[1]),
      .i2    (din[2]),
      .i3    (din[3]),
      .gnt   (gnt),
      .s     (s),
      .valid (valid),
      .out   (out)
   );

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] s;
      logic       valid;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: who owns the mux, where the rotation resumes, how long held.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;
   int m_last  = 0;

   function automatic void m_pick(input logic [3:0] rq);
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (m_ptr + k) % 4;
         if (rq[idx]) begin
            m_owner = idx;
            m_last  = idx;
            m_held  = 0;
            return;
         end
      end
      m_owner = -1;
   endfunction

   function automatic void m_step(input logic r, input logic [3:0] rq);
      if (r) begin
         m_owner = -1; m_ptr = 0; m_held = 0; m_last = 0;
      end else if (m_owner < 0) begin
         m_pick(rq);
      end else begin
         logic [3:0] others;
         bit         forced;
         others = rq & ~(4'b0001 << m_owner);
         forced = HOLD_EN && (m_held == MAX_HOLD - 1) && (others != 4'b0000);
         if (!rq[m_owner] || forced) begin
            m_ptr = (m_owner + 1) % 4;
            m_pick(rq);
         end else begin
            m_held = (m_held + 1) % MAX_HOLD;
         end
      end
   endfunction

   function automatic exp_t m_expect();
      exp_t e;
      e.valid = (m_owner >= 0);
      e.gnt   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      e.s     = 2'(m_last);
      return e;
   endfunction

   task automatic drive(input logic r, input logic [3:0] rq);
      @(negedge clk);
      rst = r;
      req = rq;
      for (int i = 0; i < 4; i++) din[i] = DW'($urandom);
      m_step(r, rq);
      exp_q.push_back(m_expect());
   endtask

   // Monitor: one registered response per clock, checked just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
         end else begin
            exp_t       e;
            logic [DW-1:0] eo;
            e  = exp_q.pop_front();
            eo = e.valid ? din[e.s] : {DW{1'b0}};
            checks++;
            if (gnt !== e.gnt) begin
               errors++;
               $display("FAIL gnt at %0t got %b want %b", $time, gnt, e.gnt);
            end
            checks++;
            if (s !== e.s) begin
               errors++;
               $display("FAIL s at %0t got %0d want %0d", $time, s, e.s);
            end
            checks++;
            if (valid !== e.valid) begin
               errors++;
               $display("FAIL valid at %0t got %b want %b", $time, valid, e.valid);
            end
            checks++;
            if (out !== eo) begin
               errors++;
               $display("FAIL out at %0t got %h want %h", $time, out, eo);
            end
         end
      end
   end

   // Stimulus: directed scenarios, then randomized traffic with occasional resets.
   initial begin
      logic [3:0] rq;
      rst = 1'b1;
      req = 4'hF;
      for (int i = 0; i < 4; i++) din[i] = DW'($urandom);
      m_step(1'b1, 4'hF);
      exp_q.push_back(m_expect());
      drive(1'b1, 4'hF);

      drive(1'b0, 4'b0100);
      drive(1'b0, 4'b0100);
      drive(1'b0, 4'b0000);
      drive(1'b0, 4'b0000);

      drive(1'b1, 4'b0000);
      drive(1'b0, 4'hF);
      drive(1'b0, 4'b1110);
      drive(1'b0, 4'b1101);
      drive(1'b0, 4'b1011);
      drive(1'b0, 4'b0111);
      drive(1'b0, 4'hF);

      drive(1'b1, 4'b0000);
      drive(1'b0, 4'b1000);
      drive(1'b0, 4'b0011);
      drive(1'b0, 4'b0010);
      drive(1'b0, 4'b0010);

      drive(1'b1, 4'b0000);
      for (int c = 0; c < 14; c++) drive(1'b0, 4'b0011);
      for (int c = 0; c < 10; c++) drive(1'b0, 4'b0001);

      drive(1'b1, 4'b0000);
      drive(1'b0, 4'b0100);
      drive(1'b0, 4'b0100);
      drive(1'b1, 4'b0100);
      drive(1'b0, 4'b0110);
      drive(1'b0, 4'b0110);

      rq = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 1) == 0) rq = 4'($urandom_range(0, 15));
         drive($urandom_range(0, 39) == 0, rq);
      end

      @(posedge clk);
      #3;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
